// File: rtl/tetris_pkg.sv
// Shared board geometry, row types and the collapse FSM state encoding.
package tetris_pkg;

  localparam int unsigned ROWS   = 23;
  localparam int unsigned COLS   = 10;
  localparam int unsigned ROW_IW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef logic [COLS-1:0]   row_t;
  typedef logic [ROW_IW-1:0] row_idx_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WRITE  = 3'd2,
    CLEAR  = 3'd3,
    FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/mask_to_index.sv
// Highest-set-bit encoder: a ROWS-bit mask to the index of its top set bit
// plus a valid flag (valid=0 for an all-zero mask, index then 0).
module mask_to_index #(
  parameter int unsigned ROWS = 23,
  parameter int unsigned IW   = 5
) (
  input  logic [ROWS-1:0] i_mask,
  output logic [IW-1:0]   o_idx_c,
  output logic            o_valid_c
);

  // Scan upward so the last (highest) set bit wins.
  always_comb begin
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (i_mask[i]) begin
        o_idx_c   = IW'(i);
        o_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/row_collapser.sv
// Row collapser: removes row k (top set bit of rowshift) from the board RAM by
// copying rows k-1..0 down one place and clearing row 0.
// Optional feature macro: ROW_COLLAPSER_SCORE_EN adds the lines_total counter.
module row_collapser #(
  parameter int unsigned ROWS = tetris_pkg::ROWS,
  parameter int unsigned COLS = tetris_pkg::COLS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ROWS-1:0]          rowshift,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(ROWS)-1:0]  mem_addr,
  output logic                     mem_we,
  output logic [COLS-1:0]          mem_wdata,
  input  logic [COLS-1:0]          mem_rdata
`ifdef ROW_COLLAPSER_SCORE_EN
  ,
  output logic [15:0]              lines_total
`endif
);

  import tetris_pkg::*;

  localparam int unsigned AW = $clog2(ROWS);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_nxt;
  logic [AW-1:0] w_k;
  logic          w_k_valid;

  logic          r_busy;
  logic          r_done;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic          w_we_nxt;
  logic [AW-1:0] w_addr_nxt;

  mask_to_index #(
    .ROWS (ROWS),
    .IW   (AW)
  ) u_mask_to_index (
    .i_mask    (rowshift),
    .o_idx_c   (w_k),
    .o_valid_c (w_k_valid)
  );

  // Next state, pointer and the registered outputs for the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = '0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_ptr_nxt = w_k;
          if (!w_k_valid)       w_state_nxt = FINISH;
          else if (w_k == '0)   w_state_nxt = CLEAR;
          else                  w_state_nxt = READ;
        end
      end
      READ:   w_state_nxt = WRITE;
      WRITE: begin
        w_ptr_nxt   = r_ptr - AW'(1);
        w_state_nxt = (w_ptr_nxt == '0) ? CLEAR : READ;
      end
      CLEAR:  w_state_nxt = FINISH;
      FINISH: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (w_state_nxt == FINISH);
    case (w_state_nxt)
      READ:  w_addr_nxt = w_ptr_nxt - AW'(1);
      WRITE: begin
        w_addr_nxt = w_ptr_nxt;
        w_we_nxt   = 1'b1;
      end
      CLEAR: w_we_nxt = 1'b1;
      default: ;
    endcase
  end

  // State, pointer and output registers; reset aborts any collapse at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign mem_we   = r_we;
  assign mem_addr = r_addr;
  // RAM read data only arrives in the WRITE cycle, so write data is a mux.
  assign mem_wdata = (r_state == WRITE) ? mem_rdata : '0;

`ifdef ROW_COLLAPSER_SCORE_EN
  logic        r_nonzero;
  logic [15:0] r_lines_total;

  // Remember whether the accepted request carried a nonzero mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_nonzero <= 1'b0;
    else if (r_state == IDLE && start) r_nonzero <= w_k_valid;
  end

  // Saturating count of collapsed lines, bumped once per nonzero FINISH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_lines_total <= 16'h0000;
    else if (r_state == FINISH && r_nonzero && r_lines_total != 16'hFFFF)
      r_lines_total <= r_lines_total + 16'h0001;
  end

  assign lines_total = r_lines_total;
`else
  // Score counter not built.
`endif

endmodule

// File: tb/tb_row_collapser.sv
// Directed bench for row_collapser with a synchronous-read board RAM model.
module tb_row_collapser;

  localparam int unsigned ROWS = 23;
  localparam int unsigned COLS = 10;
  localparam int unsigned AW   = 5;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [ROWS-1:0] rowshift;
  logic            busy;
  logic            done;
  logic [AW-1:0]   mem_addr;
  logic            mem_we;
  logic [COLS-1:0] mem_wdata;
  logic [COLS-1:0] mem_rdata;
`ifdef ROW_COLLAPSER_SCORE_EN
  logic [15:0]     lines_total;
`endif

  logic [COLS-1:0] ram [ROWS];
  logic            preload;

  int n_checks;
  int n_fail;

  typedef struct {
    string           name;
    logic [ROWS-1:0] mask;
    int              k;       // -1 for a null request
    int              lat;
    int              writes;
    bit              restart;
  } vec_t;

  vec_t vecs [7];

  row_collapser #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rowshift  (rowshift),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef ROW_COLLAPSER_SCORE_EN
    ,
    .lines_total (lines_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [COLS-1:0] pat(input int r);
    return COLS'(r * 37 + 5);
  endfunction

  // Board RAM: synchronous read, write on mem_we, bulk preload on request.
  always @(posedge clk) begin
    if (preload) begin
      for (int r = 0; r < ROWS; r++) ram[r] <= pat(r);
    end else if (mem_we && int'(mem_addr) < ROWS) begin
      ram[mem_addr] <= mem_wdata;
    end
    if (int'(mem_addr) < ROWS) mem_rdata <= ram[mem_addr];
    else                       mem_rdata <= '0;
  end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_preload();
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    int wr;
    int hi;
    int busy_low;
    logic [COLS-1:0] exp_row;
    do_preload();
    rowshift = v.mask;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    rowshift = 23'h000003;
    cyc = 1; wr = 0; hi = 0; busy_low = 0;
    while (!done && cyc < 100) begin
      if (!busy) busy_low++;
      if (mem_we) begin
        wr++;
        if (int'(mem_addr) > v.k) hi++;
      end
      start = (v.restart && cyc == 5);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!busy) busy_low++;
    if (mem_we) wr++;
    check({v.name, " latency"}, cyc, v.lat);
    check({v.name, " writes"}, wr, v.writes);
    check({v.name, " writes above k"}, hi, 0);
    check({v.name, " busy low in collapse"}, busy_low, 0);
    @(negedge clk);
    check({v.name, " busy after done"}, int'(busy), 0);
    check({v.name, " done one cycle"}, int'(done), 0);
    for (int r = 0; r < int'(ROWS); r++) begin
      if (v.k < 0 || r > v.k) exp_row = pat(r);
      else if (r == 0)        exp_row = '0;
      else                    exp_row = pat(r - 1);
      check($sformatf("%s row%0d", v.name, r), int'(ram[r]), int'(exp_row));
    end
  endtask

  initial begin
    int cyc;
    int wr;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    rowshift = '0;
    preload  = 1'b0;

    vecs[0] = '{"k4",     23'h00001F,  4, 10,  5, 1'b0};
    vecs[1] = '{"null",   23'h000000, -1,  1,  0, 1'b0};
    vecs[2] = '{"k0",     23'h000001,  0,  2,  1, 1'b0};
    vecs[3] = '{"k22",    23'h7FFFFF, 22, 46, 23, 1'b1};
    vecs[4] = '{"gap",    23'h000005,  2,  6,  3, 1'b0};
    vecs[5] = '{"bit10",  23'h000400, 10, 22, 11, 1'b0};
    vecs[6] = '{"top",    23'h400000, 22, 46, 23, 1'b0};

    // Reset values.
    #22;
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst we", int'(mem_we), 0);
    check("rst addr", int'(mem_addr), 0);
    check("rst wdata", int'(mem_wdata), 0);
`ifdef ROW_COLLAPSER_SCORE_EN
    check("rst lines_total", int'(lines_total), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset pulsed during a WRITE of a k=10 collapse.
    do_preload();
    rowshift = 23'h0007FF;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!(mem_we && mem_addr != '0) && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("abort reached write", cyc, 2);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort we", int'(mem_we), 0);
    check("abort addr", int'(mem_addr), 0);
    check("abort wdata", int'(mem_wdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wr = 0;
    for (int c = 0; c < 5; c++) begin
      if (mem_we || busy || done) wr++;
      @(negedge clk);
    end
    check("abort quiet after", wr, 0);
    run_vec(vecs[0]);

`ifdef ROW_COLLAPSER_SCORE_EN
    // Saturation of the line counter from a preset near the top.
    @(negedge clk);
    force dut.r_lines_total = 16'hFFFE;
    @(negedge clk);
    release dut.r_lines_total;
    run_vec(vecs[2]);
    check("score 1", int'(lines_total), 32'h0000FFFF);
    run_vec(vecs[0]);
    check("score 2", int'(lines_total), 32'h0000FFFF);
    run_vec(vecs[1]);
    check("score null", int'(lines_total), 32'h0000FFFF);
    run_vec(vecs[4]);
    check("score 3", int'(lines_total), 32'h0000FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
